charrom_arbiter: RTL and testbench

- Time-shares the single combinational character ROM read port (11-bit address {char, yaddr, xaddr}, 3-bit data) between two requesters.
- Requester 0 is the text-overlay pixel pipeline; requester 1 is the sprite/logo fetcher.
- Arbitration is round-robin with an optional bounded burst lock.
- Read data is registered and returned to the granted requester one cycle after the grant.

---
 rtl/charrom_arbiter_if.sv | 54 +++++
 rtl/charrom_arbiter.sv | 127 ++++++++++++
 tb/tb_charrom_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/charrom_arbiter_if.sv
// ---------------------------------------------------------------------------
// charrom_arbiter_if
//   Groups the signals between the two character-ROM requesters, the
//   arbiter and the combinational character ROM.
//
//   Requester side (driven by master):
//     req0/req1    read request
//     char0/char1  character select
//     x0/x1, y0/y1 5-bit pixel address inside the glyph
//     lock0/lock1  ask to keep ownership next cycle
//     rom_data     3-bit ROM data output (ROM model lives on master side)
//   Arbiter side (driven by slave):
//     gnt0/gnt1          combinational grant
//     rvalid0/rvalid1    registered: rdata belongs to that requester
//     rdata              registered ROM data
//     rom_char/xaddr/yaddr  address into the ROM read port
// ---------------------------------------------------------------------------
interface charrom_arbiter_if;
    logic       req0;
    logic       char0;
    logic [4:0] x0;
    logic [4:0] y0;
    logic       lock0;
    logic       req1;
    logic       char1;
    logic [4:0] x1;
    logic [4:0] y1;
    logic       lock1;
    logic       gnt0;
    logic       gnt1;
    logic       rvalid0;
    logic       rvalid1;
    logic [2:0] rdata;
    logic       rom_char;
    logic [4:0] rom_xaddr;
    logic [4:0] rom_yaddr;
    logic [2:0] rom_data;

    modport master (
        output req0, char0, x0, y0, lock0,
        output req1, char1, x1, y1, lock1,
        output rom_data,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
        input  rom_char, rom_xaddr, rom_yaddr
    );

    modport slave (
        input  req0, char0, x0, y0, lock0,
        input  req1, char1, x1, y1, lock1,
        input  rom_data,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
        output rom_char, rom_xaddr, rom_yaddr
    );
endinterface

// File: rtl/charrom_arbiter.sv
// ---------------------------------------------------------------------------
// charrom_arbiter
//   Time-shares the single combinational character ROM read port between
//   the text-overlay pipeline (requester 0) and the sprite/logo fetcher
//   (requester 1). Round-robin arbitration with an optional bounded burst
//   lock; ROM data is registered and tagged with rvalid0/rvalid1 one cycle
//   after the grant.
//
//   Ports:
//     clk    system pixel clock
//     rst_n  synchronous active-low reset
//     bus    charrom_arbiter_if.slave (requests, grants, read data, ROM port)
//
//   Parameter:
//     MAX_BURST  consecutive grants a locking owner may hold while the other
//                requester waits (1..255; 1 disables locking)
// ---------------------------------------------------------------------------
module charrom_arbiter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    charrom_arbiter_if.slave  bus
);

    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    // Per-requester views so the mux and grant logic can be indexed by winner
    logic [1:0] req;
    logic [1:0] lock;
    logic [1:0] chr;
    logic [4:0] xa [2];
    logic [4:0] ya [2];

    assign req  = {bus.req1,  bus.req0};
    assign lock = {bus.lock1, bus.lock0};
    assign chr  = {bus.char1, bus.char0};
    assign xa[0] = bus.x0;
    assign xa[1] = bus.x1;
    assign ya[0] = bus.y0;
    assign ya[1] = bus.y1;

    // State
    logic       last_reg,      last_next;
    logic       hold_reg,      hold_next;
    logic [7:0] burst_cnt_reg, burst_cnt_next;
    logic [1:0] rvalid_reg,    rvalid_next;
    logic [2:0] rdata_reg,     rdata_next;

    logic       any_req;
    logic       burst_ok;
    logic       win;
    logic [1:0] gnt;

    // Winner selection. A burst continues only if the previous grant was
    // locked, the owner still asserts lock, and the burst budget is not used
    // up; otherwise a tie goes to the requester that was not served last.
    always_comb begin
        any_req  = |req;
        burst_ok = hold_reg && lock[last_reg] && (burst_cnt_reg < MAX_BURST_C);
        win      = 1'b0;
        if (&req) begin
            win = burst_ok ? last_reg : ~last_reg;
        end else begin
            win = req[1];
        end
    end

    // One-hot grant, qualified by any request so idle cycles grant nobody
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt[gi] = any_req && (win == 1'(gi));
        end
    endgenerate

    assign bus.gnt0 = gnt[0];
    assign bus.gnt1 = gnt[1];

    // ROM address mux; zero when idle so the ROM sees a quiet bus
    assign bus.rom_char  = any_req ? chr[win] : 1'b0;
    assign bus.rom_xaddr = any_req ? xa[win]  : 5'd0;
    assign bus.rom_yaddr = any_req ? ya[win]  : 5'd0;

    // Next-state logic
    always_comb begin
        rdata_next     = rdata_reg;
        last_next      = last_reg;
        hold_next      = 1'b0;
        burst_cnt_next = 8'd0;
        rvalid_next    = gnt;
        if (any_req) begin
            rdata_next = bus.rom_data;
            last_next  = win;
            hold_next  = lock[win];
            if (hold_reg && (win == last_reg)) begin
                // Saturate rather than wrap so an uncontended owner never
                // appears to have a fresh budget.
                burst_cnt_next = (burst_cnt_reg >= MAX_BURST_C) ? MAX_BURST_C
                                                                : burst_cnt_reg + 8'd1;
            end else begin
                burst_cnt_next = 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_reg      <= 1'b1;   // requester 0 wins the first tie
            hold_reg      <= 1'b0;
            burst_cnt_reg <= 8'd0;
            rvalid_reg    <= 2'b00;
            rdata_reg     <= 3'd0;
        end else begin
            last_reg      <= last_next;
            hold_reg      <= hold_next;
            burst_cnt_reg <= burst_cnt_next;
            rvalid_reg    <= rvalid_next;
            rdata_reg     <= rdata_next;
        end
    end

    assign bus.rvalid0 = rvalid_reg[0];
    assign bus.rvalid1 = rvalid_reg[1];
    assign bus.rdata   = rdata_reg;

endmodule

// File: tb/tb_charrom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_charrom_arbiter
//   Directed bench for charrom_arbiter with MAX_BURST=4. A behavioural ROM
//   (data = address mod 7) sits on the ROM port. Inputs are driven 1 ns
//   after the rising edge, grants are sampled on the falling edge and the
//   registered outputs 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_charrom_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    charrom_arbiter_if bus ();

    charrom_arbiter #(.MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [2:0] rom_fn(input logic [10:0] a);
        return 3'(a % 11'd7);
    endfunction

    assign bus.rom_data = rom_fn({bus.rom_char, bus.rom_yaddr, bus.rom_xaddr});

    int vectors = 0;
    int miscompares = 0;

    // Address patterns used for each requester in cycle i
    function automatic logic [10:0] a0(input int i);
        return {i[0], 5'(i + 3), 5'(i)};
    endfunction

    function automatic logic [10:0] a1(input int i);
        return {~i[0], 5'(i * 3), 5'(i + 9)};
    endfunction

    task automatic drive(input logic r0, input logic l0,
                         input logic r1, input logic l1, input int i);
        logic [10:0] p0;
        logic [10:0] p1;
        p0 = a0(i);
        p1 = a1(i);
        bus.req0  = r0;
        bus.lock0 = l0;
        bus.char0 = p0[10];
        bus.y0    = p0[9:5];
        bus.x0    = p0[4:0];
        bus.req1  = r1;
        bus.lock1 = l1;
        bus.char1 = p1[10];
        bus.y1    = p1[9:5];
        bus.x1    = p1[4:0];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({bus.rvalid1, bus.rvalid0, bus.rdata} !== 5'b00_000) begin
            miscompares++;
            $display("FAIL reset_regs: got rvalid=%b%b rdata=%0d want 00 0",
                     bus.rvalid1, bus.rvalid0, bus.rdata);
        end
        @(negedge clk);
        vectors++;
        if ({bus.gnt1, bus.gnt0, bus.rom_char, bus.rom_yaddr, bus.rom_xaddr} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_idle: got gnt=%b%b rom=%h want 00 000",
                     bus.gnt1, bus.gnt0, {bus.rom_char, bus.rom_yaddr, bus.rom_xaddr});
        end
        @(posedge clk); #1;
        $display("txn reset: idle bus after reset");
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
        bus.req0 = 1'b1; bus.char0 = 1'b1; bus.x0 = 5'd3; bus.y0 = 5'd7;
        @(negedge clk);
        vectors++;
        if ({bus.gnt1, bus.gnt0} !== 2'b01) begin
            miscompares++;
            $display("FAIL single_gnt: got %b%b want 01", bus.gnt1, bus.gnt0);
        end
        vectors++;
        if ({bus.rom_char, bus.rom_yaddr, bus.rom_xaddr} !== 11'h4E3) begin
            miscompares++;
            $display("FAIL single_addr: got %h want 4e3",
                     {bus.rom_char, bus.rom_yaddr, bus.rom_xaddr});
        end
        @(posedge clk); #1;
        vectors++;
        if ({bus.rvalid1, bus.rvalid0, bus.rdata} !== {2'b01, 3'd5}) begin
            miscompares++;
            $display("FAIL single_rdata: got rvalid=%b%b rdata=%0d want 01 5",
                     bus.rvalid1, bus.rvalid0, bus.rdata);
        end
        $display("txn single: req0 addr 4e3 -> rdata %0d", bus.rdata);
        // Idle cycle: no grant, quiet ROM bus, rdata held
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        vectors++;
        if ({bus.gnt1, bus.gnt0, bus.rom_char, bus.rom_yaddr, bus.rom_xaddr} !== 13'd0) begin
            miscompares++;
            $display("FAIL idle_bus: got gnt=%b%b rom=%h want 00 000",
                     bus.gnt1, bus.gnt0, {bus.rom_char, bus.rom_yaddr, bus.rom_xaddr});
        end
        @(posedge clk); #1;
        vectors++;
        if ({bus.rvalid1, bus.rvalid0, bus.rdata} !== {2'b00, 3'd5}) begin
            miscompares++;
            $display("FAIL idle_hold: got rvalid=%b%b rdata=%0d want 00 5",
                     bus.rvalid1, bus.rvalid0, bus.rdata);
        end
        $display("txn idle: no grant, rdata held at %0d", bus.rdata);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        logic [2:0] exp_d;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, i);
            @(negedge clk);
            vectors++;
            if ({bus.gnt1, bus.gnt0} !== exp_g[i]) begin
                miscompares++;
                $display("FAIL rr_gnt[%0d]: got %b%b want %b", i, bus.gnt1, bus.gnt0, exp_g[i]);
            end
            exp_d = exp_g[i][1] ? rom_fn(a1(i)) : rom_fn(a0(i));
            @(posedge clk); #1;
            vectors++;
            if ({bus.rvalid1, bus.rvalid0, bus.rdata} !== {exp_g[i], exp_d}) begin
                miscompares++;
                $display("FAIL rr_rdata[%0d]: got rvalid=%b%b rdata=%0d want %b %0d",
                         i, bus.rvalid1, bus.rvalid0, bus.rdata, exp_g[i], exp_d);
            end
            $display("txn rr %0d: gnt=%b rdata=%0d", i, exp_g[i], exp_d);
        end
    endtask

    task automatic test_burst_limit();
        logic [1:0] exp_g [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                                  2'b01, 2'b01, 2'b01, 2'b01};
        logic [2:0] exp_d;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, i);
            @(negedge clk);
            vectors++;
            if ({bus.gnt1, bus.gnt0} !== exp_g[i]) begin
                miscompares++;
                $display("FAIL burst_gnt[%0d]: got %b%b want %b", i, bus.gnt1, bus.gnt0, exp_g[i]);
            end
            exp_d = exp_g[i][1] ? rom_fn(a1(i)) : rom_fn(a0(i));
            @(posedge clk); #1;
            vectors++;
            if ({bus.rvalid1, bus.rvalid0, bus.rdata} !== {exp_g[i], exp_d}) begin
                miscompares++;
                $display("FAIL burst_rdata[%0d]: got rvalid=%b%b rdata=%0d want %b %0d",
                         i, bus.rvalid1, bus.rvalid0, bus.rdata, exp_g[i], exp_d);
            end
            $display("txn burst %0d: gnt=%b rdata=%0d", i, exp_g[i], exp_d);
        end
    endtask

    task automatic test_uncontended_saturate();
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, i);
            @(negedge clk);
            if ({bus.gnt1, bus.gnt0} !== 2'b01) bad++;
            @(posedge clk); #1;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL solo_gnt: got %0d non-01 grants in 20 cycles want 0", bad);
        end
        $display("txn solo: 20 locked grants to requester 0");
        // Budget already spent, so the first contended cycle goes to 1
        drive(1'b1, 1'b1, 1'b1, 1'b0, 20);
        @(negedge clk);
        vectors++;
        if ({bus.gnt1, bus.gnt0} !== 2'b10) begin
            miscompares++;
            $display("FAIL solo_switch: got %b%b want 10", bus.gnt1, bus.gnt0);
        end
        @(posedge clk); #1;
        vectors++;
        if ({bus.rvalid1, bus.rvalid0, bus.rdata} !== {2'b10, rom_fn(a1(20))}) begin
            miscompares++;
            $display("FAIL solo_switch_rdata: got rvalid=%b%b rdata=%0d want 10 %0d",
                     bus.rvalid1, bus.rvalid0, bus.rdata, rom_fn(a1(20)));
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 21);
        @(negedge clk);
        vectors++;
        if ({bus.gnt1, bus.gnt0} !== 2'b01) begin
            miscompares++;
            $display("FAIL solo_back: got %b%b want 01", bus.gnt1, bus.gnt0);
        end
        @(posedge clk); #1;
        $display("txn solo: contended grants 10 then 01");
    endtask

    task automatic test_lock_drop();
        logic [1:0] exp_g [3] = '{2'b01, 2'b01, 2'b10};
        logic       lk    [3] = '{1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, lk[i], 1'b1, 1'b0, i);
            @(negedge clk);
            vectors++;
            if ({bus.gnt1, bus.gnt0} !== exp_g[i]) begin
                miscompares++;
                $display("FAIL lockdrop_gnt[%0d]: got %b%b want %b", i, bus.gnt1, bus.gnt0, exp_g[i]);
            end
            @(posedge clk); #1;
            $display("txn lockdrop %0d: lock0=%b gnt=%b", i, lk[i], exp_g[i]);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, i);
            @(posedge clk); #1;
        end
        vectors++;
        if ({bus.rvalid1, bus.rvalid0, bus.rdata} !== {2'b01, rom_fn(a0(1))}) begin
            miscompares++;
            $display("FAIL rstmid_pre: got rvalid=%b%b rdata=%0d want 01 %0d",
                     bus.rvalid1, bus.rvalid0, bus.rdata, rom_fn(a0(1)));
        end
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2);
        @(posedge clk); #1;
        rst_n = 1'b1;
        vectors++;
        if ({bus.rvalid1, bus.rvalid0, bus.rdata} !== 5'b00_000) begin
            miscompares++;
            $display("FAIL rstmid_clear: got rvalid=%b%b rdata=%0d want 00 0",
                     bus.rvalid1, bus.rvalid0, bus.rdata);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3);
        @(negedge clk);
        vectors++;
        if ({bus.gnt1, bus.gnt0} !== 2'b01) begin
            miscompares++;
            $display("FAIL rstmid_tie: got %b%b want 01", bus.gnt1, bus.gnt0);
        end
        @(posedge clk); #1;
        vectors++;
        if ({bus.rvalid1, bus.rvalid0, bus.rdata} !== {2'b01, rom_fn(a0(3))}) begin
            miscompares++;
            $display("FAIL rstmid_rdata: got rvalid=%b%b rdata=%0d want 01 %0d",
                     bus.rvalid1, bus.rvalid0, bus.rdata, rom_fn(a0(3)));
        end
        $display("txn rstmid: reset during burst, next tie to requester 0");
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_burst_limit();
        test_uncontended_saturate();
        test_lock_drop();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
